// File: rtl/rbt_s_post_deparser.sv
// rbt_s_post_deparser: egress header deparser.
// Rebuilds tuser metadata from the PHV, then serializes the flat header into AXI-Stream beats.
// Headers with a zero pkt_valid byte or zero length are consumed and counted, not emitted.
module rbt_s_post_deparser #(
    parameter int unsigned HEADER_WIDTH = 2048,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned PHV_WIDTH    = 408,
    parameter int unsigned PHV_B_NUM    = 7,
    parameter int unsigned PHV_H_NUM    = 2,
    parameter int unsigned USER_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_hdr_valid,
    output logic                    in_hdr_ready,
    input  logic [HEADER_WIDTH-1:0] in_hdr_data,
    input  logic [PHV_WIDTH-1:0]    in_hdr_phv,
    input  logic [15:0]             in_hdr_length,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic [31:0]             drop_count
);

    localparam int unsigned MaxBytes    = HEADER_WIDTH / 8;
    localparam int unsigned MaxBeats    = HEADER_WIDTH / DATA_WIDTH;
    localparam int unsigned BeatW       = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
    localparam int unsigned RemW        = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;
    localparam int unsigned HBase       = 8 * PHV_B_NUM;
    localparam int unsigned PhvFieldEnd = HBase + 16 * PHV_H_NUM;

    typedef enum logic {StIdle, StSend} state_e;

    state_e                  state_q, state_d;
    logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [BeatW-1:0]        last_beat_q, last_beat_d;
    logic [RemW-1:0]         rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
    logic [31:0]             drop_q, drop_d;

    logic [15:0]      len_eff;
    logic [15:0]      num_beats;
    logic [BeatW-1:0] acc_last;
    logic [RemW-1:0]  acc_rem;
    logic [63:0]      meta;
    logic [BeatW-1:0] beat_nxt;
    logic             is_last_nxt;

    // B4, the H fields past H0 and the reserved PHV tail carry nothing this stage needs.
    logic unused_phv;
    assign unused_phv = ^{in_hdr_phv[PHV_WIDTH-1:PhvFieldEnd],
                          in_hdr_phv[PhvFieldEnd-1:HBase+16],
                          in_hdr_phv[39:32]};

    // Selects beat n of a flat header vector.
    function automatic logic [DATA_WIDTH-1:0] beat_slice(input logic [HEADER_WIDTH-1:0] hdr,
                                                          input logic [BeatW-1:0] n);
        beat_slice = '0;
        for (int unsigned b = 0; b < MaxBeats; b++) begin
            if (n == BeatW'(b)) beat_slice = hdr[b*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    // Byte enables: all ones, except a partial last beat keeps its low rem bytes.
    function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic is_last,
                                                         input logic [RemW-1:0] rem);
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            beat_keep[i] = !is_last || (rem == '0) || (RemW'(i) < rem);
        end
    endfunction

    assign in_hdr_ready  = (state_q == StIdle);
    assign m_axis_tvalid = (state_q == StSend);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign drop_count    = drop_q;

    // Length clamp, beat bookkeeping and tuser repacking for the header on the input.
    always_comb begin
        len_eff   = (in_hdr_length > 16'(MaxBytes)) ? 16'(MaxBytes) : in_hdr_length;
        num_beats = (len_eff + 16'(KEEP_WIDTH - 1)) / 16'(KEEP_WIDTH);
        acc_last  = BeatW'(num_beats - 16'd1);
        acc_rem   = RemW'(len_eff % 16'(KEEP_WIDTH));
        meta      = {in_hdr_phv[HBase +: 16],  // pktlen = H0
                     in_hdr_phv[55:48],        // seatl = B6
                     in_hdr_phv[15:8],         // pkt_valid = B1
                     in_hdr_phv[7:0],          // property = B0
                     in_hdr_phv[47:40],        // tid = B5
                     in_hdr_phv[31:24],        // out_port = B3
                     in_hdr_phv[23:16]};       // in_port = B2
        beat_nxt    = beat_q + BeatW'(1);
        is_last_nxt = (beat_nxt == last_beat_q);
    end

    // Next-state: accept or drop in idle, step through beats on each handshake in send.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        rem_d       = rem_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        drop_d      = drop_q;
        unique case (state_q)
            StIdle: begin
                if (in_hdr_valid) begin
                    if ((in_hdr_phv[15:8] != 8'd0) && (len_eff != 16'd0)) begin
                        state_d     = StSend;
                        hdr_d       = in_hdr_data;
                        beat_d      = '0;
                        last_beat_d = acc_last;
                        rem_d       = acc_rem;
                        tdata_d     = in_hdr_data[DATA_WIDTH-1:0];
                        tkeep_d     = beat_keep(acc_last == '0, acc_rem);
                        tlast_d     = (acc_last == '0);
                        tuser_d     = USER_WIDTH'(meta);
                    end else begin
                        drop_d = drop_q + 32'd1;
                    end
                end
            end
            StSend: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d = StIdle;
                        tdata_d = '0;
                        tkeep_d = '0;
                        tlast_d = 1'b0;
                        tuser_d = '0;
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = beat_slice(hdr_q, beat_nxt);
                        tkeep_d = beat_keep(is_last_nxt, rem_q);
                        tlast_d = is_last_nxt;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hdr_q       <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            rem_q       <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            rem_q       <= rem_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_rbt_s_post_deparser.sv
// Directed bench for rbt_s_post_deparser: inputs driven and outputs sampled on the falling edge.
module tb_rbt_s_post_deparser;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_hdr_valid;
    logic          in_hdr_ready;
    logic [2047:0] in_hdr_data;
    logic [407:0]  in_hdr_phv;
    logic [15:0]   in_hdr_length;
    logic [511:0]  m_axis_tdata;
    logic [63:0]   m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [63:0]   m_axis_tuser;
    logic [31:0]   drop_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rbt_s_post_deparser dut (
        .clk           (clk),
        .rst           (rst),
        .in_hdr_valid  (in_hdr_valid),
        .in_hdr_ready  (in_hdr_ready),
        .in_hdr_data   (in_hdr_data),
        .in_hdr_phv    (in_hdr_phv),
        .in_hdr_length (in_hdr_length),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .drop_count    (drop_count)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hbyte(input int seed, input int k);
        return 8'((k * 13 + seed * 29 + 5) & 255);
    endfunction

    function automatic logic [2047:0] mk_hdr(input int seed);
        logic [2047:0] h;
        for (int k = 0; k < 256; k++) h[8*k +: 8] = hbyte(seed, k);
        return h;
    endfunction

    // PHV with noise in B4, H1 and the upper reserved bits.
    function automatic logic [407:0] mk_phv(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input logic [7:0] b5, input logic [7:0] b6,
                                            input logic [15:0] h0);
        logic [407:0] p;
        p          = '0;
        p[7:0]     = b0;
        p[15:8]    = b1;
        p[23:16]   = b2;
        p[31:24]   = b3;
        p[39:32]   = 8'h99;
        p[47:40]   = b5;
        p[55:48]   = b6;
        p[71:56]   = h0;
        p[87:72]   = 16'hBEEF;
        p[407:400] = 8'hA5;
        return p;
    endfunction

    function automatic logic [63:0] exp_keep(input int len_eff, input int n);
        int          nb;
        int          r;
        logic [63:0] k;
        nb = (len_eff + 63) / 64;
        r  = len_eff % 64;
        k  = '1;
        if (n == nb - 1 && r != 0) k = (64'd1 << r) - 64'd1;
        return k;
    endfunction

    function automatic logic [511:0] exp_beat(input int seed, input int n, input logic [63:0] keep);
        logic [511:0] d;
        d = '0;
        for (int j = 0; j < 64; j++) if (keep[j]) d[8*j +: 8] = hbyte(seed, n * 64 + j);
        return d;
    endfunction

    function automatic logic [511:0] mask_data(input logic [511:0] d, input logic [63:0] keep);
        logic [511:0] o;
        for (int j = 0; j < 64; j++) o[8*j +: 8] = keep[j] ? d[8*j +: 8] : 8'h00;
        return o;
    endfunction

    // Present a header at the current falling edge; unless held, withdraw it after one edge.
    task automatic send_hdr(input int seed, input logic [407:0] phv, input logic [15:0] len,
                            input bit hold_valid);
        in_hdr_data   = mk_hdr(seed);
        in_hdr_phv    = phv;
        in_hdr_length = len;
        in_hdr_valid  = 1'b1;
        if (!hold_valid) begin
            @(negedge clk);
            in_hdr_valid  = 1'b0;
            in_hdr_data   = '1;
            in_hdr_phv    = '1;
            in_hdr_length = 16'hAAAA;
        end
    endtask

    // Receive all beats of one header, then check the idle bubble that follows.
    task automatic collect(input string tag, input int seed, input int len_eff,
                           input logic [63:0] tuser, input bit toggle);
        int          nb;
        int          n;
        int          cyc;
        bit          tog;
        logic [63:0] ek;
        nb  = (len_eff + 63) / 64;
        n   = 0;
        cyc = 0;
        tog = 1'b0;
        while (n < nb && cyc < 64) begin
            m_axis_tready = toggle ? tog : 1'b1;
            tog = !tog;
            chk({tag, "_tvalid"}, m_axis_tvalid, 1);
            if (m_axis_tvalid) begin
                ek = exp_keep(len_eff, n);
                chk({tag, "_ready_busy"}, in_hdr_ready, 0);
                chk({tag, "_tkeep"}, m_axis_tkeep, ek);
                chk({tag, "_tlast"}, m_axis_tlast, (n == nb - 1));
                chk({tag, "_tuser"}, m_axis_tuser, tuser);
                chk({tag, "_tdata"}, mask_data(m_axis_tdata, ek), exp_beat(seed, n, ek));
                if (m_axis_tready) n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_beats"}, n, nb);
        chk({tag, "_bubble_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_bubble_ready"}, in_hdr_ready, 1);
        m_axis_tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [407:0] phv;
        rst           = 1'b1;
        in_hdr_valid  = 1'b0;
        in_hdr_data   = '0;
        in_hdr_phv    = '0;
        in_hdr_length = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ready", in_hdr_ready, 1);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_drop", drop_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-beat header with the hand-computed tuser and tkeep
        phv = mk_phv(8'h11, 8'h01, 8'h03, 8'h05, 8'h07, 8'h22, 16'h05DC);
        send_hdr(1, phv, 16'd40, 1'b0);
        chk("single_latency", m_axis_tvalid, 1);
        chk("single_tkeep_const", m_axis_tkeep, 64'h0000_00FF_FFFF_FFFF);
        chk("single_tuser_const", m_axis_tuser, 64'h05DC_2201_1107_0503);
        collect("single", 1, 40, 64'h05DC_2201_1107_0503, 1'b0);

        // Multi-beat with tready toggling; beat 3 keeps 8 bytes
        phv = mk_phv(8'hA0, 8'h05, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 16'h00C8);
        send_hdr(2, phv, 16'd200, 1'b0);
        chk("multi_keep3_const", exp_keep(200, 3), 64'hFF);
        collect("multi", 2, 200, 64'h00C8_0E05_A00D_0C0B, 1'b1);

        // Drop by pkt_valid = 0, then by length 0, back to back
        phv = mk_phv(8'h01, 8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 16'h0040);
        send_hdr(3, phv, 16'd64, 1'b0);
        chk("drop_pv_tvalid", m_axis_tvalid, 0);
        chk("drop_pv_ready", in_hdr_ready, 1);
        chk("drop_pv_count", drop_count, 1);
        phv = mk_phv(8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 16'h0000);
        send_hdr(3, phv, 16'd0, 1'b0);
        chk("drop_len0_tvalid", m_axis_tvalid, 0);
        chk("drop_len0_count", drop_count, 2);
        chk("drop_len0_ready", in_hdr_ready, 1);
        phv = mk_phv(8'h31, 8'h02, 8'h32, 8'h33, 8'h35, 8'h36, 16'h1234);
        send_hdr(4, phv, 16'd64, 1'b0);
        chk("after_drop_tvalid", m_axis_tvalid, 1);
        collect("after_drop", 4, 64, 64'h1234_3602_3135_3332, 1'b0);

        // Overlong length clamps to 256 bytes
        phv = mk_phv(8'h41, 8'h03, 8'h42, 8'h43, 8'h45, 8'h46, 16'hFFFF);
        send_hdr(5, phv, 16'hFFFF, 1'b0);
        collect("overlong", 5, 256, 64'hFFFF_4603_4145_4342, 1'b0);

        // Back-to-back: second header waits on the input while the first is sent
        phv = mk_phv(8'h51, 8'h01, 8'h52, 8'h53, 8'h55, 8'h56, 16'h0040);
        send_hdr(6, phv, 16'd64, 1'b1);
        @(negedge clk);
        in_hdr_data   = mk_hdr(7);
        in_hdr_phv    = mk_phv(8'h61, 8'h01, 8'h62, 8'h63, 8'h65, 8'h66, 16'h0082);
        in_hdr_length = 16'd130;
        collect("b2b_a", 6, 64, 64'h0040_5601_5155_5352, 1'b0);
        @(negedge clk);
        in_hdr_valid = 1'b0;
        chk("b2b_one_idle", m_axis_tvalid, 1);
        collect("b2b_b", 7, 130, 64'h0082_6601_6165_6362, 1'b0);
        chk("b2b_last_keep_const", exp_keep(130, 2), 64'h3);
        chk("b2b_drop", drop_count, 2);

        // Reset during beat 1 of a 4-beat header
        phv = mk_phv(8'h71, 8'h01, 8'h72, 8'h73, 8'h75, 8'h76, 16'h0100);
        send_hdr(8, phv, 16'd256, 1'b0);
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("rst_mid_beat1", mask_data(m_axis_tdata, '1), exp_beat(8, 1, '1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_ready", in_hdr_ready, 1);
        chk("rst_mid_drop", drop_count, 0);
        phv = mk_phv(8'h81, 8'h07, 8'h82, 8'h83, 8'h85, 8'h86, 16'h0064);
        send_hdr(9, phv, 16'd100, 1'b0);
        collect("post_rst", 9, 100, 64'h0064_8607_8185_8382, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
